// File: rtl/mul_writeback_buffer.sv
// mul_writeback_buffer: buffers int8 MUL result vectors in a FIFO and streams them to memory.
// Ports: clk/rst (sync active-high), start_i/base_addr_i/total_elems_i job setup,
//   issue_i/credit_ok_o upstream credit, valid_i/data_i MUL results,
//   m_valid_o/m_ready_i/m_data_o/m_strb_o/m_addr_o/m_last_o output stream,
//   busy_o/done_o status, overflow_o sticky overrun flag.
// Define MUL_WB_OVERFLOW_CHECK_EN to build the overflow detector; otherwise overflow_o is tied 0.
module mul_writeback_buffer #(
  parameter int MAX_VECTOR_SIZE = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [31:0]                  total_elems_i,
  input  logic                         issue_i,
  output logic                         credit_ok_o,
  input  logic                         valid_i,
  input  logic [8*MAX_VECTOR_SIZE-1:0] data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [8*MAX_VECTOR_SIZE-1:0] m_data_o,
  output logic [MAX_VECTOR_SIZE-1:0]   m_strb_o,
  output logic [ADDR_W-1:0]            m_addr_o,
  output logic                         m_last_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
);
  localparam int INT8_SIZE = 8;
  localparam int DW = INT8_SIZE * MAX_VECTOR_SIZE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = MAX_VECTOR_SIZE > 1 ? $clog2(MAX_VECTOR_SIZE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [31:0] beats_q, received, sent, inflight;
  logic [ADDR_W-1:0] addr_q;
  logic [RW-1:0] rem_q;
  logic credit_q, full, push, pop, wr_en, last_beat;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign m_valid_o = count != '0;
  assign pop = m_valid_o && m_ready_i;
  assign push = valid_i && state == RUN && received < beats_q;
  // a push into a full FIFO only lands when the head leaves in the same cycle
  assign wr_en = push && (!full || pop);
  assign last_beat = sent == beats_q - 32'd1;
  assign m_data_o = m_valid_o ? mem[rd_ptr] : '0;
  assign m_addr_o = m_valid_o ? addr_q : '0;
  assign m_last_o = m_valid_o && last_beat;
  assign m_strb_o = !m_valid_o ? '0 : (last_beat && rem_q != '0) ? ~({MAX_VECTOR_SIZE{1'b1}} << rem_q) : '1;
  assign credit_ok_o = credit_q;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  always_comb
    state_n = state == IDLE ? (start_i ? (total_elems_i == '0 ? DONE : RUN) : IDLE) :
              state == RUN  ? (pop && last_beat ? DONE : RUN) : IDLE;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      beats_q <= '0;
      rem_q <= '0;
      received <= '0;
      sent <= '0;
      inflight <= '0;
      addr_q <= '0;
      credit_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start_i) begin
        beats_q <= total_elems_i / 32'(MAX_VECTOR_SIZE) + 32'(total_elems_i % 32'(MAX_VECTOR_SIZE) != '0);
        rem_q <= RW'(total_elems_i % 32'(MAX_VECTOR_SIZE));
        received <= '0;
        sent <= '0;
        addr_q <= base_addr_i;
      end
      if (push) received <= received + 32'd1;
      if (pop) begin
        sent <= sent + 32'd1;
        addr_q <= addr_q + ADDR_W'(MAX_VECTOR_SIZE);
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      count <= count + (PW+1)'(wr_en) - (PW+1)'(pop);
      inflight <= inflight + 32'(issue_i) - 32'(push && inflight != '0);
      // everything already promised (buffered + in MUL + issuing now) must leave room
      credit_q <= state_n == RUN && (32'(count) + inflight + 32'(issue_i) < 32'(FIFO_DEPTH));
    end
  end
`ifdef MUL_WB_OVERFLOW_CHECK_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if ((push && full && !pop) || (valid_i && state == RUN && inflight == '0)) ovf_q <= 1'b1;
  end
  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_mul_writeback_buffer.sv
// tb_mul_writeback_buffer: directed self-checking bench for mul_writeback_buffer.
module tb_mul_writeback_buffer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, issue = 1'b0, valid = 1'b0, m_ready = 1'b1;
  logic [31:0] base = '0, tot = '0;
  logic [63:0] data = '0;
  logic credit_ok, m_valid, m_last, busy, done, overflow;
  logic [63:0] m_data;
  logic [7:0] m_strb;
  logic [31:0] m_addr;
  int total = 0, bad = 0;
`ifdef MUL_WB_OVERFLOW_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif
  mul_writeback_buffer dut (
    .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base), .total_elems_i(tot),
    .issue_i(issue), .credit_ok_o(credit_ok), .valid_i(valid), .data_i(data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_strb_o(m_strb),
    .m_addr_o(m_addr), .m_last_o(m_last), .busy_o(busy), .done_o(done), .overflow_o(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] pat(int i);
    return 64'h0101010101010101 * 64'(i + 1);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic job(input logic [31:0] b, input logic [31:0] t);
    base = b;
    tot = t;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic send_beat(input logic [63:0] d);
    issue = 1'b1;
    tick;
    issue = 1'b0;
    valid = 1'b1;
    data = d;
    tick;
    valid = 1'b0;
  endtask
  // upstream issues whenever credit allows; MUL returns each vector one cycle later
  task automatic fill(output int n);
    logic pend;
    int nv;
    n = 0;
    nv = 0;
    pend = 1'b0;
    for (int c = 0; c < 20; c++) begin
      issue = credit_ok;
      valid = pend;
      data = pend ? pat(nv) : '0;
      tick;
      if (pend) nv++;
      if (issue) n++;
      pend = issue;
    end
    issue = 1'b0;
    valid = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++; if ({m_valid, m_last, busy, done, credit_ok, overflow} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {m_valid, m_last, busy, done, credit_ok, overflow}); end
    total++; if ({m_data, m_strb, m_addr} !== '0) begin bad++; $display("FAIL reset_bus got=%h exp=0", {m_data, m_strb, m_addr}); end
    rst = 1'b0;
    tick;
  endtask
  task automatic test_basic;
    m_ready = 1'b1;
    job(32'h100, 32'd16);
    total++; if ({busy, credit_ok} !== 2'b11) begin bad++; $display("FAIL t1_busy_credit got=%b exp=11", {busy, credit_ok}); end
    send_beat(64'h1122334455667788);
    total++; if (m_valid !== 1'b1 || m_data !== 64'h1122334455667788) begin bad++; $display("FAIL t1_beat0_data got=%b/%h exp=1/1122334455667788", m_valid, m_data); end
    total++; if (m_addr !== 32'h100 || m_strb !== 8'hFF || m_last !== 1'b0) begin bad++; $display("FAIL t1_beat0_meta got=%h/%h/%b exp=100/ff/0", m_addr, m_strb, m_last); end
    tick;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL t1_popped got=%b exp=0", m_valid); end
    send_beat(64'h99AABBCCDDEEFF00);
    total++; if (m_data !== 64'h99AABBCCDDEEFF00 || m_addr !== 32'h108 || m_strb !== 8'hFF || m_last !== 1'b1) begin bad++; $display("FAIL t1_beat1 got=%h/%h/%h/%b exp=99aabbccddeeff00/108/ff/1", m_data, m_addr, m_strb, m_last); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done_early got=%b exp=0", done); end
    tick;
    total++; if (done !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL t1_done got=%b/%b exp=1/0", done, m_valid); end
    tick;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t1_idle got=%b/%b exp=0/0", done, busy); end
  endtask
  task automatic test_partial_and_empty;
    job(32'h200, 32'd13);
    send_beat(pat(0));
    total++; if (m_strb !== 8'hFF || m_last !== 1'b0) begin bad++; $display("FAIL t2_beat0 got=%h/%b exp=ff/0", m_strb, m_last); end
    tick;
    send_beat(pat(1));
    total++; if (m_strb !== 8'h1F || m_last !== 1'b1 || m_data !== pat(1) || m_addr !== 32'h208) begin bad++; $display("FAIL t2_tail got=%h/%b/%h/%h exp=1f/1/%h/208", m_strb, m_last, m_data, m_addr, pat(1)); end
    tick;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL t2_done got=%b exp=1", done); end
    tick;
    job(32'h300, 32'd0);
    total++; if (done !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL t2_zero got=%b/%b exp=1/0", done, m_valid); end
    tick;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t2_zero_idle got=%b/%b exp=0/0", done, busy); end
  endtask
  task automatic test_credit;
    int n;
    m_ready = 1'b0;
    job(32'h0, 32'd64);
    fill(n);
    total++; if (n !== 8) begin bad++; $display("FAIL t3_issues got=%0d exp=8", n); end
    total++; if (credit_ok !== 1'b0 || overflow !== 1'b0 || m_valid !== 1'b1) begin bad++; $display("FAIL t3_full got=%b/%b/%b exp=0/0/1", credit_ok, overflow, m_valid); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (m_valid !== 1'b1 || m_data !== pat(i) || m_addr !== 32'(i * 8) || m_last !== (i == 7)) begin bad++; $display("FAIL t3_drain%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", i, m_valid, m_data, m_addr, m_last, pat(i), i * 8, i == 7); end
      tick;
    end
    total++; if (done !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL t3_done got=%b/%b exp=1/0", done, m_valid); end
    tick;
  endtask
  task automatic test_full_push_pop;
    int n;
    m_ready = 1'b0;
    job(32'h1000, 32'd72);
    fill(n);
    issue = 1'b1;
    tick;
    issue = 1'b0;
    total++; if (m_data !== pat(0)) begin bad++; $display("FAIL t4_head got=%h exp=%h", m_data, pat(0)); end
    m_ready = 1'b1;
    valid = 1'b1;
    data = pat(8);
    tick;
    valid = 1'b0;
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b1 || m_data !== pat(1) || m_addr !== 32'h1008) begin bad++; $display("FAIL t4_after got=%b/%h/%h exp=1/%h/1008", m_valid, m_data, m_addr, pat(1)); end
    tick;
    m_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      total++; if (m_valid !== 1'b1 || m_data !== pat(i) || m_addr !== 32'h1000 + 32'(i * 8) || m_last !== (i == 8)) begin bad++; $display("FAIL t4_drain%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", i, m_valid, m_data, m_addr, m_last, pat(i), 32'h1000 + 32'(i * 8), i == 8); end
      tick;
    end
    total++; if (done !== 1'b1 || m_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL t4_done got=%b/%b/%b exp=1/0/0", done, m_valid, overflow); end
    tick;
  endtask
  task automatic test_mid_reset;
    m_ready = 1'b0;
    job(32'h500, 32'd48);
    for (int i = 0; i < 3; i++) send_beat(pat(i));
    total++; if (m_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL t5_pre got=%b/%b exp=1/1", m_valid, busy); end
    rst = 1'b1;
    tick;
    total++; if ({m_valid, m_last, busy, done, credit_ok, overflow} !== 6'b0 || {m_data, m_strb, m_addr} !== '0) begin bad++; $display("FAIL t5_reset got=%b/%h exp=0/0", {m_valid, m_last, busy, done, credit_ok, overflow}, {m_data, m_strb, m_addr}); end
    rst = 1'b0;
    m_ready = 1'b1;
    job(32'h40, 32'd8);
    send_beat(64'hCAFEF00DDEADBEEF);
    total++; if (m_data !== 64'hCAFEF00DDEADBEEF || m_addr !== 32'h40 || m_strb !== 8'hFF || m_last !== 1'b1) begin bad++; $display("FAIL t5_new got=%h/%h/%h/%b exp=cafef00ddeadbeef/40/ff/1", m_data, m_addr, m_strb, m_last); end
    tick;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL t5_done got=%b exp=1", done); end
    tick;
  endtask
  task automatic test_overflow;
    int n;
    m_ready = 1'b0;
    job(32'h0, 32'd80);
    fill(n);
    valid = 1'b1;
    data = 64'hFFFFFFFFFFFFFFFF;
    tick;
    valid = 1'b0;
    total++; if (overflow !== OVF_EXP || m_data !== pat(0)) begin bad++; $display("FAIL t6_ovf got=%b/%h exp=%b/%h", overflow, m_data, OVF_EXP, pat(0)); end
    tick;
    tick;
    total++; if (overflow !== OVF_EXP) begin bad++; $display("FAIL t6_sticky got=%b exp=%b", overflow, OVF_EXP); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t6_clear got=%b exp=0", overflow); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_partial_and_empty;
    test_credit;
    test_full_push_pop;
    test_mid_reset;
    test_overflow;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
